// File: rtl/alu_control_seq.sv
// ALU control decoder with a three-state sequencer for multi-cycle MULT/DIV.
// Decoded select/flags are captured at accept and held until the next accept.
module alu_control_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] ALUOp,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] sel,
    output logic       illegal,
    output logic       multi,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The EXEC state is entered with N-2 loaded so that N edges elapse in total.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES - 2);

    if ((MUL_CYCLES < 2) || (MUL_CYCLES > 2**CNT_W) ||
        (DIV_CYCLES < 2) || (DIV_CYCLES > 2**CNT_W)) begin : g_cfg_err
        $error("alu_control_seq: MUL_CYCLES/DIV_CYCLES must lie in 2..2**CNT_W");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;

    logic [3:0]       dec_sel;
    logic             dec_illegal;
    logic             dec_multi;
    logic [CNT_W-1:0] dec_cnt;

    always_comb begin
        dec_sel     = 4'b0000;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        dec_cnt     = '0;
        case (ALUOp)
            2'b00: dec_sel = 4'b0010;
            2'b01: dec_sel = 4'b0110;
            2'b11: dec_sel = 4'b0111;
            default: begin
                case (funct)
                    6'b100000: dec_sel = 4'b0010;
                    6'b100010: dec_sel = 4'b0110;
                    6'b100100: dec_sel = 4'b0000;
                    6'b100101: dec_sel = 4'b0001;
                    6'b101010: dec_sel = 4'b0111;
                    6'b100110: dec_sel = 4'b0011;
                    6'b100111: dec_sel = 4'b1100;
                    6'b011000: begin
                        dec_sel   = 4'b1000;
                        dec_multi = 1'b1;
                        dec_cnt   = MUL_CNT;
                    end
                    6'b011010: begin
                        dec_sel   = 4'b1001;
                        dec_multi = 1'b1;
                        dec_cnt   = DIV_CNT;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            sel     <= 4'b0000;
            illegal <= 1'b0;
            multi   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sel     <= dec_sel;
                        illegal <= dec_illegal;
                        multi   <= dec_multi;
                        if (dec_multi) begin
                            counter <= dec_cnt;
                            state   <= EXEC;
                        end else begin
                            state   <= DONE;
                        end
                    end
                end
                EXEC: begin
                    if (counter == '0) begin
                        state <= DONE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == EXEC);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed scenarios plus randomized ops
// compared against a table-driven decode/latency model.
module tb_alu_control_seq;

    localparam int MULN = 4;
    localparam int DIVN = 16;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [5:0] funct;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sel;
    logic       illegal;
    logic       multi;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    alu_control_seq #(
        .MUL_CYCLES(MULN),
        .DIV_CYCLES(DIVN),
        .CNT_W(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ALUOp(ALUOp),
        .funct(funct),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel(sel),
        .illegal(illegal),
        .multi(multi),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // R-type table: funct, select, cycles (1 = single-cycle)
    localparam logic [5:0] T_FN  [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                         6'b101010, 6'b100110, 6'b100111, 6'b011000, 6'b011010};
    localparam logic [3:0] T_SEL [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                         4'b0111, 4'b0011, 4'b1100, 4'b1000, 4'b1001};
    localparam int         T_CYC [9] = '{1, 1, 1, 1, 1, 1, 1, MULN, DIVN};

    task automatic model(input logic [1:0] op, input logic [5:0] fn,
                         output logic [3:0] esel, output logic eill,
                         output logic emul, output int lat);
        esel = 4'b0000; eill = 1'b0; emul = 1'b0; lat = 1;
        if (op == 2'b00)      esel = 4'b0010;
        else if (op == 2'b01) esel = 4'b0110;
        else if (op == 2'b11) esel = 4'b0111;
        else begin
            eill = 1'b1;
            for (int i = 0; i < 9; i++) begin
                if (T_FN[i] == fn) begin
                    esel = T_SEL[i];
                    eill = 1'b0;
                    lat  = T_CYC[i];
                    emul = (T_CYC[i] > 1);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_multi"}, 32'(multi), 32'd0);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input int hold, input bit early, input bit noise);
        logic [3:0] esel;
        logic eill, emul;
        int lat, edges, busyc;
        model(op, fn, esel, eill, emul, lat);
        ALUOp = op; funct = fn; in_valid = 1'b1; out_ready = early;
        @(negedge clock);
        in_valid = 1'b0;
        edges = 1; busyc = 0;
        while (out_valid !== 1'b1 && edges < 64) begin
            if (busy === 1'b1) busyc++;
            if (noise) begin
                in_valid = 1'($urandom); ALUOp = 2'($urandom); funct = 6'($urandom);
            end
            @(negedge clock);
            edges++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(edges), 32'(lat));
        chk({tag, "_busy_cycles"}, 32'(busyc), 32'(lat - 1));
        chk({tag, "_sel"}, 32'(sel), 32'(esel));
        chk({tag, "_illegal"}, 32'(illegal), 32'(eill));
        chk({tag, "_multi"}, 32'(multi), 32'(emul));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                if (noise || h == 0) begin
                    in_valid = 1'b1; ALUOp = 2'b01; funct = 6'($urandom);
                end
                @(negedge clock);
                in_valid = 1'b0;
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_sel"}, 32'(sel), 32'(esel));
                chk({tag, "_hold_illegal"}, 32'(illegal), 32'(eill));
                chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_sel_held"}, 32'(sel), 32'(esel));
        chk({tag, "_idle_multi_held"}, 32'(multi), 32'(emul));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ALUOp = 2'b00; funct = 6'b0;
        repeat (2) @(negedge clock);
        chk_reset_state("reset");
        reset = 1'b0;

        run_op("t1_add", 2'b00, 6'b000000, 1, 1'b0, 1'b0);
        run_op("t2_nor", 2'b10, 6'b100111, 0, 1'b1, 1'b0);
        run_op("t3_div", 2'b10, 6'b011010, 1, 1'b0, 1'b0);
        run_op("t4_bad", 2'b10, 6'b111111, 2, 1'b0, 1'b0);
        run_op("t4_sub", 2'b01, 6'b111111, 1, 1'b0, 1'b0);

        // reset during the second EXEC cycle of a MULT
        ALUOp = 2'b10; funct = 6'b011000; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk("t5_busy_exec1", 32'(busy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_state("t5_abort");
        reset = 1'b0;
        @(negedge clock);
        chk("t5_stay_idle", 32'(out_valid), 32'd0);

        // reset and in_valid together: op must not be taken
        reset = 1'b1; in_valid = 1'b1; ALUOp = 2'b01;
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk_reset_state("rst_vs_valid");

        run_op("t6_done_stall", 2'b10, 6'b100101, 5, 1'b0, 1'b0);
        run_op("t6_mult_noise", 2'b10, 6'b011000, 5, 1'b0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom);
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : T_FN[$urandom_range(0, 8)];
            run_op("rand", op, fn, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
